// File: rtl/strhw_common_types_pkg.sv
// ---------------------------------------------------------------------------
// strhw_common_types
//   Shared types and constants for the Streebog hardware blocks.
//   uint512            : one full 512-bit Streebog word (N, Sigma, block).
//   STRHW_BLOCK_BITS   : message block size in bits.
//   STRHW_N_INCREMENT  : amount N advances by for every full block processed.
// ---------------------------------------------------------------------------
package strhw_common_types;

  typedef logic [511:0] uint512;

  localparam int STRHW_BLOCK_BITS  = 512;
  localparam int STRHW_N_INCREMENT = 512;

endpackage

// File: rtl/strhw_adder_seg.sv
// ---------------------------------------------------------------------------
// strhw_adder_seg
//   One slice of the segmented adder: adds two SEG_W-bit operand segments
//   plus a carry and registers the sum and the carry out. The registers hold
//   while en is low and clear on a synchronous reset.
//
// Ports:
//   clk_i  in   clock
//   rst_i  in   synchronous active-high reset
//   en     in   register enable (pipeline advance)
//   a, b   in   SEG_W-bit operand segments
//   cin    in   carry into the segment's bit 0
//   sum    out  registered SEG_W-bit segment sum
//   cout   out  registered carry out of the segment's top bit
// ---------------------------------------------------------------------------
module strhw_adder_seg #(
  parameter int SEG_W = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  // One extra bit on the left captures the carry out of the segment.
  logic [SEG_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      sum  <= total[SEG_W-1:0];
      cout <= total[SEG_W];
    end
  end

endmodule

// File: rtl/strhw_adder_pipe.sv
// ---------------------------------------------------------------------------
// strhw_adder_pipe
//   Segmented, pipelined modular adder:
//     {carry_o, sum_o} = a_i + b_i + carry_i   (sum_o is mod 2^WIDTH)
//   The carry chain is cut into SEGMENTS slices of SEG_W bits, one slice per
//   pipeline stage. Upper operand segments wait in a triangular delay buffer
//   until their stage is reached; finished lower sum segments are delayed so
//   every segment of one operation reaches sum_o together. Latency is
//   SEGMENTS enabled cycles, throughput one operation per cycle. A stalled
//   output (valid_o && !ready_i) freezes the entire pipe.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset
//   valid_i  in   operands present on a_i/b_i/carry_i
//   ready_o  out  operands accepted this cycle (combinational)
//   a_i      in   WIDTH-bit addend A
//   b_i      in   WIDTH-bit addend B
//   carry_i  in   carry into bit 0
//   valid_o  out  sum_o/carry_o valid
//   ready_i  in   downstream accepts the result
//   sum_o    out  (a_i + b_i + carry_i) mod 2^WIDTH
//   carry_o  out  carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module strhw_adder_pipe
  import strhw_common_types::*;
#(
  parameter int WIDTH    = STRHW_BLOCK_BITS,
  parameter int SEGMENTS = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  if (SEGMENTS < 1 || (WIDTH % SEGMENTS) != 0) begin : g_param_check
    $error("strhw_adder_pipe: SEGMENTS must be >= 1 and divide WIDTH");
  end

  localparam int SEG_W = WIDTH / SEGMENTS;

  logic                en;
  logic [SEGMENTS-1:0] valid_q;
  // carry_chain[0] is the external carry; carry_chain[k+1] is the registered
  // carry out of stage k, consumed by stage k+1 one cycle later.
  logic [SEGMENTS:0]   carry_chain;
  logic [SEG_W-1:0]    seg_a   [SEGMENTS];
  logic [SEG_W-1:0]    seg_b   [SEGMENTS];
  logic [SEG_W-1:0]    seg_sum [SEGMENTS];
  logic [SEG_W-1:0]    out_sum [SEGMENTS];

  // The only reason to hold the pipe is a result that cannot leave.
  assign en             = !(valid_o && !ready_i);
  assign ready_o        = en;
  assign valid_o        = valid_q[SEGMENTS-1];
  assign carry_chain[0] = carry_i;
  assign carry_o        = carry_chain[SEGMENTS];

  // Valid bits travel alongside the data; a bubble clears stage 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q[0] <= valid_i;
      for (int k = 1; k < SEGMENTS; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage

    if (k == 0) begin : g_direct
      assign seg_a[k] = a_i[SEG_W-1:0];
      assign seg_b[k] = b_i[SEG_W-1:0];
    end else begin : g_op_delay
      // Segment k is needed k cycles after acceptance, so it rides a
      // k-deep shift register; together these form the triangular buffer.
      logic [SEG_W-1:0] a_sr [k];
      logic [SEG_W-1:0] b_sr [k];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < k; i++) begin
            a_sr[i] <= '0;
            b_sr[i] <= '0;
          end
        end else if (en) begin
          a_sr[0] <= a_i[k*SEG_W +: SEG_W];
          b_sr[0] <= b_i[k*SEG_W +: SEG_W];
          for (int i = 1; i < k; i++) begin
            a_sr[i] <= a_sr[i-1];
            b_sr[i] <= b_sr[i-1];
          end
        end
      end

      assign seg_a[k] = a_sr[k-1];
      assign seg_b[k] = b_sr[k-1];
    end

    strhw_adder_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en    (en),
      .a     (seg_a[k]),
      .b     (seg_b[k]),
      .cin   (carry_chain[k]),
      .sum   (seg_sum[k]),
      .cout  (carry_chain[k+1])
    );

    if (k == SEGMENTS - 1) begin : g_no_sum_delay
      assign out_sum[k] = seg_sum[k];
    end else begin : g_sum_delay
      // Lower segments finish early and wait here for the top segment.
      localparam int DEPTH = SEGMENTS - 1 - k;
      logic [SEG_W-1:0] sum_sr [DEPTH];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) begin
            sum_sr[i] <= '0;
          end
        end else if (en) begin
          sum_sr[0] <= seg_sum[k];
          for (int i = 1; i < DEPTH; i++) begin
            sum_sr[i] <= sum_sr[i-1];
          end
        end
      end

      assign out_sum[k] = sum_sr[DEPTH-1];
    end

    assign sum_o[k*SEG_W +: SEG_W] = out_sum[k];
  end

endmodule

// File: tb/tb_strhw_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_strhw_adder_pipe
//   Drives four adder instances (SEGMENTS = 1, 2, 4, 8; WIDTH = 512) with the
//   same operand stream. Directed vectors check reset state, latency, carry
//   propagation across segment boundaries, streaming, stalls and mid-flight
//   reset; a per-instance scoreboard checks every result against the
//   513-bit reference sum.
// ---------------------------------------------------------------------------
module tb_strhw_adder_pipe;
  import strhw_common_types::*;

  localparam int W    = STRHW_BLOCK_BITS;
  localparam int NDUT = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   valid_i;
  logic   ready_i;
  logic   carry_i;
  uint512 a_i;
  uint512 b_i;

  logic   valid_o_w [NDUT];
  logic   ready_o_w [NDUT];
  logic   carry_o_w [NDUT];
  uint512 sum_o_w   [NDUT];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W:0] observed,
                             input logic [W:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input uint512 a, input uint512 b, input logic c,
                               input logic v);
    a_i     = a;
    b_i     = b;
    carry_i = c;
    valid_i = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instance g has SEGMENTS = 2**g and its own in-order scoreboard.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int S = 1 << g;
    logic [W:0] exp_q [$];

    strhw_adder_pipe #(
      .WIDTH    (W),
      .SEGMENTS (S)
    ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid_i),
      .ready_o (ready_o_w[g]),
      .a_i     (a_i),
      .b_i     (b_i),
      .carry_i (carry_i),
      .valid_o (valid_o_w[g]),
      .ready_i (ready_i),
      .sum_o   (sum_o_w[g]),
      .carry_o (carry_o_w[g])
    );

    // Handshakes are evaluated mid-cycle for the coming rising edge.
    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
      end else begin
        if (valid_o_w[g] && ready_i) begin
          if (exp_q.size() == 0) begin
            checkOutput($sformatf("sb_s%0d_pending", S), (W+1)'(exp_q.size()), 1);
          end else begin
            checkOutput($sformatf("sb_s%0d_result", S), {carry_o_w[g], sum_o_w[g]},
                        exp_q.pop_front());
          end
        end
        if (valid_i && ready_o_w[g]) begin
          exp_q.push_back({1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, carry_i});
        end
      end
    end
  end

  // One operation into an idle pipe: latency and result on every instance.
  task automatic runOp(input string tag, input uint512 a, input uint512 b,
                       input logic c, input logic [W:0] expected);
    int         seen [NDUT];
    logic [W:0] cap  [NDUT];
    for (int i = 0; i < NDUT; i++) begin
      seen[i] = -1;
      cap[i]  = '0;
    end
    ready_i = 1'b1;
    applyStimulus(a, b, c, 1'b1);
    step();
    applyStimulus('0, '0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      for (int i = 0; i < NDUT; i++) begin
        if (valid_o_w[i] && seen[i] < 0) begin
          seen[i] = cyc;
          cap[i]  = {carry_o_w[i], sum_o_w[i]};
        end
      end
      step();
    end
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("%s_latency_s%0d", tag, 1 << i), seen[i], (1 << i) - 1);
      checkOutput($sformatf("%s_sum_s%0d", tag, 1 << i), cap[i], expected);
    end
  endtask

  initial begin
    uint512     ones;
    uint512     ra;
    uint512     rb;
    logic [W:0] frozen;
    int         cnt;
    int         k;
    int         saw [NDUT];

    rst     = 1'b1;
    ready_i = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    repeat (2) step();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_valid", valid_o_w[1], 0);
    checkOutput("rst_sum", sum_o_w[1], 0);
    checkOutput("rst_carry", carry_o_w[1], 0);
    checkOutput("rst_ready", ready_o_w[1], 1);

    $display("[TB] wrap-around and segment-boundary carries");
    ones = '1;
    runOp("wrap", ones, '0, 1'b1, {1'b1, {W{1'b0}}});
    runOp("cross256", ones >> 256, uint512'(1), 1'b0, {1'b0, uint512'(1) << 256});
    runOp("cross128", ones >> 384, uint512'(1), 1'b0, {1'b0, uint512'(1) << 128});

    $display("[TB] back-to-back stream");
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) applyStimulus(uint512'(c * STRHW_N_INCREMENT), uint512'(STRHW_N_INCREMENT), 1'b0, 1'b1);
      else       applyStimulus('0, '0, 1'b0, 1'b0);
      #1;
      if (c < 8) checkOutput("stream_ready", ready_o_w[1], 1);
      step();
      checkOutput($sformatf("stream_valid_c%0d", c), valid_o_w[1], (c >= 1 && c <= 8) ? 1 : 0);
      if (valid_o_w[1]) begin
        checkOutput("stream_sum", sum_o_w[1], (cnt + 1) * 512);
        cnt++;
      end
    end
    checkOutput("stream_count", cnt, 8);

    $display("[TB] stream with back-pressure");
    k      = 0;
    cnt    = 0;
    frozen = '0;
    for (int c = 0; c < 40 && cnt < 8; c++) begin
      ready_i = !(c >= 3 && c < 6);
      if (k < 8) applyStimulus(uint512'(k * 512), uint512'(512), 1'b0, 1'b1);
      else       applyStimulus('0, '0, 1'b0, 1'b0);
      #1;
      if (!ready_i) begin
        checkOutput("stall_ready", ready_o_w[1], 0);
        if (c == 3) frozen = {carry_o_w[1], sum_o_w[1]};
        else        checkOutput("stall_frozen", {carry_o_w[1], sum_o_w[1]}, frozen);
      end
      if (valid_i && ready_o_w[1]) k++;
      if (valid_o_w[1] && ready_i) begin
        checkOutput("stall_order", sum_o_w[1], (cnt + 1) * 512);
        cnt++;
      end
      step();
    end
    checkOutput("stall_count", cnt, 8);
    checkOutput("stall_accepted", k, 8);
    ready_i = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    repeat (12) step();

    $display("[TB] reset with operations in flight");
    applyStimulus(uint512'(100), uint512'(200), 1'b0, 1'b1);
    step();
    applyStimulus(uint512'(300), uint512'(400), 1'b1, 1'b1);
    step();
    rst = 1'b1;
    applyStimulus(uint512'(9), uint512'(9), 1'b0, 1'b1);
    step();
    rst = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("midrst_valid", valid_o_w[1], 0);
    checkOutput("midrst_sum", sum_o_w[1], 0);
    checkOutput("midrst_carry", carry_o_w[1], 0);
    checkOutput("midrst_ready", ready_o_w[1], 1);
    for (int i = 0; i < NDUT; i++) saw[i] = 0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NDUT; i++) if (valid_o_w[i]) saw[i] = 1;
      step();
    end
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("midrst_quiet_s%0d", 1 << i), saw[i], 0);
    end
    runOp("after_rst", uint512'(5), uint512'(7), 1'b0, 513'd12);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < 16; j++) begin
        ra[j*32 +: 32] = $urandom;
        rb[j*32 +: 32] = $urandom;
      end
      if ($urandom_range(0, 7) == 0) ra = '1;
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    applyStimulus('0, '0, 1'b0, 1'b0);
    ready_i = 1'b1;
    repeat (16) step();
    checkOutput("drain_s1", g_dut[0].exp_q.size(), 0);
    checkOutput("drain_s2", g_dut[1].exp_q.size(), 0);
    checkOutput("drain_s4", g_dut[2].exp_q.size(), 0);
    checkOutput("drain_s8", g_dut[3].exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
